hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter STAGES, default 3, giving the in-flight depth (EX..WB) tracked after issue (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 5, giving the register-address width (REG_COUNT = 2**ADDR_W).
REQ-003 SHALL have parameter FWD_EN, default 0: 0 = stall on every RAW hazard, 1 = forward and stall only on load-use.
REQ-004 SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-005 clk1  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 id_valid  in  1  instruction present in ID.
REQ-008 id_src0, id_src1  in  ADDR_W each  source register addresses.
REQ-009 id_src_used  in  2  per-source use flags (bit0 = src0).
REQ-010 id_dst  in  ADDR_W  destination register.
REQ-011 id_wr_en  in  1  instruction writes id_dst.
REQ-012 id_is_load  in  1  result is available only at the end of stage 2.
REQ-013 id_is_halt  in  1  HLT in ID.
REQ-014 flush  in  1  taken branch; kill the ID instruction.
REQ-015 stall  out  1  hold IF/ID this cycle.
REQ-016 issue  out  1  ID instruction advances this cycle.
REQ-017 fwd_sel0, fwd_sel1  out  4 each  0 = register file, k = forward from entry k.
REQ-018 busy_mask  out  REG_COUNT  registers with pending writes.
REQ-019 halted  out  1  HLT issued; sticky.
REQ-020 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-021 SHALL keep entries 1..STAGES, each holding {valid, dst, is_load}; every cycle entry k moves to entry k+1, and entry STAGES retires.
REQ-022 SHALL compute issue = id_valid & ~stall & ~flush & ~halted, combinationally.
REQ-023 On issue, entry 1 SHALL load valid = id_wr_en & (id_dst != 0), dst = id_dst and is_load = id_is_load; otherwise entry 1 SHALL load a bubble (valid = 0).
REQ-024 Writes to R0 SHALL never create entries, hazards, or busy_mask bits.
REQ-025 Entry STAGES SHALL be excluded from hazard compares, because the register file is write-before-read.
REQ-026 A source SHALL be hazardous when its use flag is set, it is nonzero, and it matches a valid dst in entries 1..STAGES-1.
REQ-027 With FWD_EN=0, stall SHALL equal id_valid & ~halted & (any source hazardous).
REQ-028 With FWD_EN=1, stall SHALL be asserted only when the youngest match is entry 1 with is_load=1.
REQ-029 With FWD_EN=1, fwd_selN SHALL give the youngest (lowest k) matching entry; fwd_selN SHALL be 0 when there is no match or when FWD_EN=0.
REQ-030 flush SHALL override stall: issue=0, a bubble is inserted, and in-flight entries are unaffected.
REQ-031 busy_mask bit r SHALL be the OR of valid entries 1..STAGES with dst == r.
REQ-032 An issued id_is_halt SHALL set halted on the next edge; halted SHALL remain set until reset, and no issue SHALL occur afterwards.
REQ-033 In-flight entries SHALL continue to drain while halted.
REQ-034 stall_cnt SHALL increment on every cycle with stall=1 and saturate at all-ones.

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL clear all entries, halted and stall_cnt.
REQ-036 After reset, stall=0, issue=id_valid&~flush, fwd_sel=0 and busy_mask=0.
REQ-037 Reset asserted mid-stream SHALL discard in-flight entries with no retirement side effects.

Structure
REQ-038 A shared package SHALL hold the entry struct {valid, dst, is_load} and the FWD_NONE=0 constant.
REQ-039 Sub-module sb_match SHALL compare one source against all entries and return {hazard, youngest index}; it is instantiated twice.

Verification
REQ-040 FWD_EN=0, STAGES=3: ADDI R1 then ADD R4,R1,R2 back-to-back -> stall high for exactly 2 cycles, ADD issues in cycle 3, stall_cnt=2.
REQ-041 FWD_EN=1: the same sequence -> no stall, fwd_sel0=1 when the ADD issues; one instruction later, a consumer of R1 gets fwd_sel=2.
REQ-042 FWD_EN=1: LW R1 then ADD R4,R1,R2 -> one stall cycle, then issue with fwd_sel0=2.
REQ-043 ADDI R0,R0,5 then OR R7,R0,R0 -> no stall, busy_mask stays 0.
REQ-044 flush asserted together with a hazard -> issue=0, bubble inserted, stall_cnt increments; HLT issued -> halted=1 next cycle, busy_mask drains to 0 within STAGES cycles.
REQ-045 rst_n low for one cycle while entries 1..3 are valid -> busy_mask=0 and halted=0 on the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: in-flight entry
// layout and the "no forward" selector value.
package hazard_scoreboard_pkg;

    localparam int ADDR_W_MAX = 8;

    localparam logic [3:0] FWD_NONE = 4'd0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_MAX-1:0] dst;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and scoreboard response bundle.
// master drives the decoded instruction, slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    localparam int REG_COUNT = 2 ** ADDR_W;

    logic              id_valid;
    logic [ADDR_W-1:0] id_src0;
    logic [ADDR_W-1:0] id_src1;
    logic [1:0]        id_src_used;
    logic [ADDR_W-1:0] id_dst;
    logic              id_wr_en;
    logic              id_is_load;
    logic              id_is_halt;
    logic              flush;

    logic                 stall;
    logic                 issue;
    logic [3:0]           fwd_sel0;
    logic [3:0]           fwd_sel1;
    logic [REG_COUNT-1:0] busy_mask;
    logic                 halted;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output id_valid, id_src0, id_src1, id_src_used,
        output id_dst, id_wr_en, id_is_load, id_is_halt,
        output flush,
        input  stall, issue, fwd_sel0, fwd_sel1,
        input  busy_mask, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_src0, id_src1, id_src_used,
        input  id_dst, id_wr_en, id_is_load, id_is_halt,
        input  flush,
        output stall, issue, fwd_sel0, fwd_sel1,
        output busy_mask, halted, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one ID source against the hazard-visible entries and
// reports the youngest (lowest index) match.
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int ADDR_W = 5
) (
    input  logic                    [ADDR_W-1:0] src,
    input  logic                                 used,
    input  sb_entry_t [STAGES-1:1]               ent,
    output logic                                 hazard,
    output logic                    [3:0]        idx,
    output logic                                 is_load
);

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        hazard  = 1'b0;
        idx     = FWD_NONE;
        is_load = 1'b0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (used && src != '0 && ent[k].valid &&
                ent[k].dst == ADDR_W_MAX'(src)) begin
                hazard  = 1'b1;
                idx     = 4'(k);
                is_load = ent[k].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight destinations after issue
// and produces stall, forwarding selects and a busy register mask.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int ADDR_W = 5,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input logic                clk1,
    input logic                rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int REG_COUNT = 2 ** ADDR_W;

    // Last stage is kept apart: it only feeds busy_mask, since the
    // register file already returns its value to the reader.
    sb_entry_t [STAGES-1:1] ent;
    logic                   ret_valid;
    logic [ADDR_W-1:0]      ret_dst;
    logic                   halted_q;
    logic [CNT_W-1:0]       cnt_q;

    logic       hz0, hz1;
    logic [3:0] idx0, idx1;
    logic       ld0, ld1;
    logic       need_stall;
    logic       stall;
    logic       issue;
    sb_entry_t  nxt;
    logic [REG_COUNT-1:0] busy;

    sb_match #(.STAGES(STAGES), .ADDR_W(ADDR_W)) u_m0 (
        .src     (bus.id_src0),
        .used    (bus.id_src_used[0]),
        .ent     (ent),
        .hazard  (hz0),
        .idx     (idx0),
        .is_load (ld0)
    );

    sb_match #(.STAGES(STAGES), .ADDR_W(ADDR_W)) u_m1 (
        .src     (bus.id_src1),
        .used    (bus.id_src_used[1]),
        .ent     (ent),
        .hazard  (hz1),
        .idx     (idx1),
        .is_load (ld1)
    );

    always_comb begin
        need_stall = hz0 | hz1;
        if (FWD_EN != 0) begin
            need_stall = (hz0 && idx0 == 4'd1 && ld0) ||
                         (hz1 && idx1 == 4'd1 && ld1);
        end
        stall = bus.id_valid & ~halted_q & need_stall;
        issue = bus.id_valid & ~stall & ~bus.flush & ~halted_q;

        nxt.valid   = issue & bus.id_wr_en & (bus.id_dst != '0);
        nxt.dst     = ADDR_W_MAX'(bus.id_dst);
        nxt.is_load = bus.id_is_load;
    end

    always_comb begin
        busy = '0;
        for (int k = 1; k <= STAGES - 1; k++) begin
            if (ent[k].valid) begin
                busy[ent[k].dst[ADDR_W-1:0]] = 1'b1;
            end
        end
        if (ret_valid) begin
            busy[ret_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            ent       <= '0;
            ret_valid <= 1'b0;
            ret_dst   <= '0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ent[1] <= nxt;
            for (int k = 2; k <= STAGES - 1; k++) begin
                ent[k] <= ent[k-1];
            end
            ret_valid <= ent[STAGES-1].valid;
            ret_dst   <= ent[STAGES-1].dst[ADDR_W-1:0];
            if (issue && bus.id_is_halt) begin
                halted_q <= 1'b1;
            end
            if (stall && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.issue     = issue;
    assign bus.fwd_sel0  = (FWD_EN != 0) ? idx0 : FWD_NONE;
    assign bus.fwd_sel1  = (FWD_EN != 0) ? idx1 : FWD_NONE;
    assign bus.busy_mask = busy;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: one scoreboard per forwarding mode, directed scenarios plus
// random traffic against an issue-history reference model.
module tb_hazard_scoreboard;

    localparam int ST = 3;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    logic          vld[2];
    logic [AW-1:0] s0[2];
    logic [AW-1:0] s1[2];
    logic [AW-1:0] dst[2];
    logic [1:0]    used[2];
    logic          wr[2];
    logic          ld[2];
    logic          hlt[2];
    logic          fl[2];

    logic          o_st[2];
    logic          o_is[2];
    logic [3:0]    o_f0[2];
    logic [3:0]    o_f1[2];
    logic [31:0]   o_bm[2];
    logic          o_h[2];
    logic [CW-1:0] o_c[2];

    hazard_scoreboard_if #(.ADDR_W(AW), .CNT_W(CW)) bi[2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bi[g].id_valid    = vld[g];
        assign bi[g].id_src0     = s0[g];
        assign bi[g].id_src1     = s1[g];
        assign bi[g].id_src_used = used[g];
        assign bi[g].id_dst      = dst[g];
        assign bi[g].id_wr_en    = wr[g];
        assign bi[g].id_is_load  = ld[g];
        assign bi[g].id_is_halt  = hlt[g];
        assign bi[g].flush       = fl[g];
        assign o_st[g] = bi[g].stall;
        assign o_is[g] = bi[g].issue;
        assign o_f0[g] = bi[g].fwd_sel0;
        assign o_f1[g] = bi[g].fwd_sel1;
        assign o_bm[g] = bi[g].busy_mask;
        assign o_h[g]  = bi[g].halted;
        assign o_c[g]  = bi[g].stall_cnt;

        hazard_scoreboard #(
            .STAGES(ST), .ADDR_W(AW), .FWD_EN(g), .CNT_W(CW)
        ) u_dut (
            .clk1  (clk1),
            .rst_n (rst_n),
            .bus   (bi[g])
        );
    end

    // Reference: list of issued register writers with issue cycle.
    // Age 1 = issued last cycle; visible to hazards for ages
    // 1..ST-1 and to busy_mask for ages 1..ST.
    typedef struct {
        int d;
        int dst;
        bit ld;
        int cyc;
    } op_t;

    op_t hist[$];
    int  cyc = 0;
    bit  hm[2];
    int  cm[2];

    function automatic void model(
        input int d, output bit st, output bit is,
        output int f0, output int f1, output logic [31:0] bm
    );
        int y0 = 0;
        int y1 = 0;
        bit l0 = 0;
        bit l1 = 0;
        int age;
        bm = '0;
        foreach (hist[i]) begin
            if (hist[i].d == d) begin
                age = cyc - hist[i].cyc;
                if (age >= 1 && age <= ST) bm[hist[i].dst] = 1'b1;
                if (age >= 1 && age < ST) begin
                    if (used[d][0] && s0[d] != 0 &&
                        int'(s0[d]) == hist[i].dst &&
                        (y0 == 0 || age < y0)) begin
                        y0 = age;
                        l0 = hist[i].ld;
                    end
                    if (used[d][1] && s1[d] != 0 &&
                        int'(s1[d]) == hist[i].dst &&
                        (y1 == 0 || age < y1)) begin
                        y1 = age;
                        l1 = hist[i].ld;
                    end
                end
            end
        end
        if (d == 0) st = vld[d] && !hm[d] && (y0 != 0 || y1 != 0);
        else st = vld[d] && !hm[d] &&
                  ((y0 == 1 && l0) || (y1 == 1 && l1));
        is = vld[d] && !st && !fl[d] && !hm[d];
        f0 = (d == 1) ? y0 : 0;
        f1 = (d == 1) ? y1 : 0;
    endfunction

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            vld[d] = 0; s0[d] = 0; s1[d] = 0; dst[d] = 0;
            used[d] = 0; wr[d] = 0; ld[d] = 0; hlt[d] = 0;
            fl[d] = 0;
        end
    endtask

    task automatic op(
        input int d, input logic [AW-1:0] dd,
        input logic [AW-1:0] a, input logic [AW-1:0] b,
        input logic [1:0] u, input logic w, input logic l,
        input logic h, input logic f
    );
        vld[d] = 1; dst[d] = dd; s0[d] = a; s1[d] = b;
        used[d] = u; wr[d] = w; ld[d] = l; hlt[d] = h;
        fl[d] = f;
    endtask

    task automatic step();
        bit st[2];
        bit is[2];
        int f0, f1;
        logic [31:0] bm;
        op_t o;
        for (int d = 0; d < 2; d++) model(d, st[d], is[d], f0, f1, bm);
        @(posedge clk1);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int i = hist.size() - 1; i >= 0; i--)
                    if (hist[i].d == d) hist.delete(i);
                hm[d] = 0;
                cm[d] = 0;
            end else begin
                if (is[d] && wr[d] && dst[d] != 0) begin
                    o.d = d; o.dst = int'(dst[d]);
                    o.ld = ld[d]; o.cyc = cyc;
                    hist.push_back(o);
                end
                if (is[d] && hlt[d]) hm[d] = 1;
                if (st[d] && cm[d] < 2 ** CW - 1) cm[d]++;
            end
        end
        cyc++;
        for (int i = hist.size() - 1; i >= 0; i--)
            if (cyc - hist[i].cyc > ST) hist.delete(i);
        @(negedge clk1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) op(d, 4, 1, 2, 2'b11, 1, 0, 0, 0);
        step();
        rst_n = 1;
        #1;
        for (int d = 0; d < 2; d++) begin
            total += 7;
            if (o_st[d] !== 1'b0) begin
                bad++; $display("FAIL rst_stall d%0d got %b want 0", d, o_st[d]);
            end
            if (o_is[d] !== 1'b1) begin
                bad++; $display("FAIL rst_issue d%0d got %b want 1", d, o_is[d]);
            end
            if (o_f0[d] !== 4'd0 || o_f1[d] !== 4'd0) begin
                bad++; $display("FAIL rst_fwd d%0d got %0d/%0d want 0/0", d, o_f0[d], o_f1[d]);
            end
            if (o_bm[d] !== 32'h0) begin
                bad++; $display("FAIL rst_busy d%0d got %h want 0", d, o_bm[d]);
            end
            if (o_h[d] !== 1'b0) begin
                bad++; $display("FAIL rst_halted d%0d got %b want 0", d, o_h[d]);
            end
            if (o_c[d] !== '0) begin
                bad++; $display("FAIL rst_cnt d%0d got %0d want 0", d, o_c[d]);
            end
            fl[d] = 1;
            #1;
            if (o_is[d] !== 1'b0) begin
                bad++; $display("FAIL rst_flush_issue d%0d got %b want 0", d, o_is[d]);
            end
        end
        do_reset();
    endtask

    task automatic test_raw_stall();
        int ns = 0;
        bit got = 0;
        logic [CW-1:0] c_at = '0;
        do_reset();
        op(0, 1, 0, 0, 2'b01, 1, 0, 0, 0);
        step();
        op(0, 4, 1, 2, 2'b11, 1, 0, 0, 0);
        #1;
        total += 2;
        if (o_bm[0] !== 32'h2) begin
            bad++; $display("FAIL raw_busy got %h want 2", o_bm[0]);
        end
        if (o_f0[0] !== 4'd0) begin
            bad++; $display("FAIL raw_nofwd got %0d want 0", o_f0[0]);
        end
        for (int i = 0; i < 6 && !got; i++) begin
            if (o_is[0]) begin
                got = 1; c_at = o_c[0];
            end else if (o_st[0]) ns++;
            step();
            #1;
        end
        total += 3;
        if (!got) begin
            bad++; $display("FAIL raw_issue timeout got 0 want 1");
        end
        if (ns != 2) begin
            bad++; $display("FAIL raw_stalls got %0d want 2", ns);
        end
        if (c_at !== 4'd2) begin
            bad++; $display("FAIL raw_cnt got %0d want 2", c_at);
        end
        idle();
    endtask

    task automatic test_forward();
        do_reset();
        op(1, 1, 0, 0, 2'b01, 1, 0, 0, 0);
        step();
        op(1, 4, 1, 2, 2'b11, 1, 0, 0, 0);
        #1;
        total += 3;
        if (o_st[1] !== 1'b0 || o_is[1] !== 1'b1) begin
            bad++; $display("FAIL fwd_issue got st=%b is=%b want 0/1", o_st[1], o_is[1]);
        end
        if (o_f0[1] !== 4'd1) begin
            bad++; $display("FAIL fwd_sel0_e1 got %0d want 1", o_f0[1]);
        end
        if (o_f1[1] !== 4'd0) begin
            bad++; $display("FAIL fwd_sel1_none got %0d want 0", o_f1[1]);
        end
        step();
        op(1, 5, 3, 1, 2'b11, 1, 0, 0, 0);
        #1;
        total += 3;
        if (o_f1[1] !== 4'd2) begin
            bad++; $display("FAIL fwd_sel1_e2 got %0d want 2", o_f1[1]);
        end
        if (o_f0[1] !== 4'd0) begin
            bad++; $display("FAIL fwd_sel0_r3 got %0d want 0", o_f0[1]);
        end
        if (o_st[1] !== 1'b0 || o_c[1] !== '0) begin
            bad++; $display("FAIL fwd_nostall got st=%b cnt=%0d want 0/0", o_st[1], o_c[1]);
        end
        step();
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        op(1, 1, 2, 0, 2'b01, 1, 1, 0, 0);
        step();
        op(1, 4, 1, 2, 2'b11, 1, 0, 0, 0);
        #1;
        total += 2;
        if (o_st[1] !== 1'b1 || o_is[1] !== 1'b0) begin
            bad++; $display("FAIL lu_stall got st=%b is=%b want 1/0", o_st[1], o_is[1]);
        end
        if (o_f0[1] !== 4'd1) begin
            bad++; $display("FAIL lu_sel_e1 got %0d want 1", o_f0[1]);
        end
        step();
        #1;
        total += 3;
        if (o_st[1] !== 1'b0 || o_is[1] !== 1'b1) begin
            bad++; $display("FAIL lu_issue got st=%b is=%b want 0/1", o_st[1], o_is[1]);
        end
        if (o_f0[1] !== 4'd2) begin
            bad++; $display("FAIL lu_sel_e2 got %0d want 2", o_f0[1]);
        end
        if (o_c[1] !== 4'd1) begin
            bad++; $display("FAIL lu_cnt got %0d want 1", o_c[1]);
        end
        step();
        idle();
    endtask

    task automatic test_r0();
        do_reset();
        op(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        step();
        op(0, 7, 0, 0, 2'b11, 1, 0, 0, 0);
        #1;
        total += 2;
        if (o_bm[0] !== 32'h0) begin
            bad++; $display("FAIL r0_busy got %h want 0", o_bm[0]);
        end
        if (o_st[0] !== 1'b0 || o_is[0] !== 1'b1) begin
            bad++; $display("FAIL r0_issue got st=%b is=%b want 0/1", o_st[0], o_is[0]);
        end
        step();
        idle();
        #1;
        total += 1;
        if (o_bm[0] !== 32'h80) begin
            bad++; $display("FAIL r7_busy got %h want 80", o_bm[0]);
        end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        op(0, 1, 0, 0, 2'b01, 1, 0, 0, 0);
        step();
        op(0, 4, 1, 2, 2'b11, 1, 0, 0, 1);
        #1;
        total += 1;
        if (o_st[0] !== 1'b1 || o_is[0] !== 1'b0) begin
            bad++; $display("FAIL fl_kill got st=%b is=%b want 1/0", o_st[0], o_is[0]);
        end
        step();
        fl[0] = 0;
        #1;
        total += 2;
        if (o_c[0] !== 4'd1 || o_st[0] !== 1'b1) begin
            bad++; $display("FAIL fl_cnt got cnt=%0d st=%b want 1/1", o_c[0], o_st[0]);
        end
        if (o_bm[0] !== 32'h2) begin
            bad++; $display("FAIL fl_bubble got %h want 2", o_bm[0]);
        end
        step();
        #1;
        total += 1;
        if (o_is[0] !== 1'b1 || o_c[0] !== 4'd2) begin
            bad++; $display("FAIL fl_after got is=%b cnt=%0d want 1/2", o_is[0], o_c[0]);
        end
        step();
        idle();
    endtask

    task automatic test_halt();
        int k = 0;
        do_reset();
        op(0, 3, 0, 0, 2'b01, 1, 0, 0, 0);
        step();
        op(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        #1;
        total += 1;
        if (o_is[0] !== 1'b1 || o_h[0] !== 1'b0) begin
            bad++; $display("FAIL hlt_issue got is=%b h=%b want 1/0", o_is[0], o_h[0]);
        end
        step();
        op(0, 5, 3, 3, 2'b11, 1, 0, 0, 0);
        #1;
        total += 2;
        if (o_h[0] !== 1'b1 || o_is[0] !== 1'b0 || o_st[0] !== 1'b0) begin
            bad++; $display("FAIL hlt_set got h=%b is=%b st=%b want 1/0/0", o_h[0], o_is[0], o_st[0]);
        end
        if (o_bm[0] !== 32'h8) begin
            bad++; $display("FAIL hlt_busy got %h want 8", o_bm[0]);
        end
        while (o_bm[0] !== 32'h0 && k < ST) begin
            step();
            #1;
            k++;
        end
        total += 2;
        if (o_bm[0] !== 32'h0) begin
            bad++; $display("FAIL hlt_drain got %h want 0", o_bm[0]);
        end
        if (o_h[0] !== 1'b1 || o_is[0] !== 1'b0) begin
            bad++; $display("FAIL hlt_sticky got h=%b is=%b want 1/0", o_h[0], o_is[0]);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            op(0, AW'(r), 0, 0, 2'b00, 1, 0, 0, 0);
            step();
        end
        op(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        #1;
        total += 1;
        if (o_bm[0] !== 32'hE) begin
            bad++; $display("FAIL mid_full got %h want e", o_bm[0]);
        end
        step();
        rst_n = 0;
        idle();
        step();
        rst_n = 1;
        #1;
        total += 1;
        if (o_bm[0] !== 32'h0 || o_h[0] !== 1'b0) begin
            bad++; $display("FAIL mid_clear got bm=%h h=%b want 0/0", o_bm[0], o_h[0]);
        end
    endtask

    task automatic test_random();
        bit st, is;
        int f0, f1;
        logic [31:0] bm;
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            for (int d = 0; d < 2; d++) begin
                vld[d]  = ($urandom_range(0, 9) < 8);
                s0[d]   = AW'($urandom_range(0, 7));
                s1[d]   = AW'($urandom_range(0, 7));
                dst[d]  = AW'($urandom_range(0, 7));
                used[d] = 2'($urandom_range(0, 3));
                wr[d]   = ($urandom_range(0, 3) != 0);
                ld[d]   = ($urandom_range(0, 9) < 3);
                hlt[d]  = ($urandom_range(0, 59) == 0);
                fl[d]   = ($urandom_range(0, 9) == 0);
            end
            rst_n = !(($urandom_range(0, 199) == 0) ||
                      ((hm[0] || hm[1]) && $urandom_range(0, 15) == 0));
            #1;
            for (int d = 0; d < 2; d++) begin
                model(d, st, is, f0, f1, bm);
                total += 7;
                if (o_st[d] !== st) begin
                    bad++; $display("FAIL rnd_stall d%0d n%0d got %b want %b", d, n, o_st[d], st);
                end
                if (o_is[d] !== is) begin
                    bad++; $display("FAIL rnd_issue d%0d n%0d got %b want %b", d, n, o_is[d], is);
                end
                if (o_f0[d] !== 4'(f0)) begin
                    bad++; $display("FAIL rnd_fwd0 d%0d n%0d got %0d want %0d", d, n, o_f0[d], f0);
                end
                if (o_f1[d] !== 4'(f1)) begin
                    bad++; $display("FAIL rnd_fwd1 d%0d n%0d got %0d want %0d", d, n, o_f1[d], f1);
                end
                if (o_bm[d] !== bm) begin
                    bad++; $display("FAIL rnd_busy d%0d n%0d got %h want %h", d, n, o_bm[d], bm);
                end
                if (o_h[d] !== hm[d]) begin
                    bad++; $display("FAIL rnd_halted d%0d n%0d got %b want %b", d, n, o_h[d], hm[d]);
                end
                if (o_c[d] !== CW'(cm[d])) begin
                    bad++; $display("FAIL rnd_cnt d%0d n%0d got %0d want %0d", d, n, o_c[d], cm[d]);
                end
            end
            step();
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk1);
        test_reset();
        test_raw_stall();
        test_forward();
        test_load_use();
        test_r0();
        test_flush();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
